// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with programmable baud
// divisor, optional even/odd parity and one or two stop bits. Bus writes are
// queued and serialised back-to-back; status outputs feed the status read path.
module uart_tx_buffered #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          uart_sel,
    input  logic                          wr,
    input  logic [DATA_BITS-1:0]          data_in,
    input  logic [DIV_W-1:0]              baud_div,
    input  logic                          parity_en,
    input  logic                          parity_odd,
    input  logic                          two_stop,
    input  logic                          clr_ovf,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          tx_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(FIFO_DEPTH);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    state_t               state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [BIT_W-1:0]     bit_idx;
    logic [DIV_W-1:0]     baud_cnt;
    logic [DIV_W-1:0]     div_lat;
    logic                 par_en_lat;
    logic                 par_odd_lat;
    logic                 two_stop_lat;
    logic                 par_bit;
    logic                 stop_second;

    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 last_stop;
    logic                 write_req;
    logic [DATA_BITS-1:0] head;

    assign fifo_count = count;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_LEVEL);
    assign write_req  = uart_sel & wr;
    assign push       = write_req & ~fifo_full;
    assign head       = mem[rd_ptr];
    assign bit_end    = (baud_cnt == '0);
    assign last_stop  = (state == S_STOP) && bit_end && (!two_stop_lat || stop_second);
    assign pop        = !fifo_empty && ((state == S_IDLE) || last_stop);
    assign tx_done    = last_stop;
    assign busy       = (state != S_IDLE);

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; a push and pop together leave the level unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow: a dropped write beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (write_req && fifo_full) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    // Frame sequencer: loads a frame from the FIFO head, latches its configuration and drives tx
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            tx           <= 1'b1;
            shift_reg    <= '0;
            bit_idx      <= '0;
            baud_cnt     <= '0;
            div_lat      <= '0;
            par_en_lat   <= 1'b0;
            par_odd_lat  <= 1'b0;
            two_stop_lat <= 1'b0;
            par_bit      <= 1'b0;
            stop_second  <= 1'b0;
        end else begin
            if (!bit_end) begin
                baud_cnt <= baud_cnt - DIV_W'(1);
            end
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        state        <= S_START;
                        tx           <= 1'b0;
                        shift_reg    <= head;
                        par_bit      <= ^head;
                        baud_cnt     <= baud_div;
                        div_lat      <= baud_div;
                        par_en_lat   <= parity_en;
                        par_odd_lat  <= parity_odd;
                        two_stop_lat <= two_stop;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state     <= S_DATA;
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= '0;
                        baud_cnt  <= div_lat;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= div_lat;
                        if (bit_idx == LAST_BIT) begin
                            if (par_en_lat) begin
                                state <= S_PARITY;
                                tx    <= par_bit ^ par_odd_lat;
                            end else begin
                                state       <= S_STOP;
                                tx          <= 1'b1;
                                stop_second <= 1'b0;
                            end
                        end else begin
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                            bit_idx   <= bit_idx + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (bit_end) begin
                        state       <= S_STOP;
                        tx          <= 1'b1;
                        stop_second <= 1'b0;
                        baud_cnt    <= div_lat;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        if (two_stop_lat && !stop_second) begin
                            stop_second <= 1'b1;
                            baud_cnt    <= div_lat;
                        end else if (pop) begin
                            state        <= S_START;
                            tx           <= 1'b0;
                            shift_reg    <= head;
                            par_bit      <= ^head;
                            baud_cnt     <= baud_div;
                            div_lat      <= baud_div;
                            par_en_lat   <= parity_en;
                            par_odd_lat  <= parity_odd;
                            two_stop_lat <= two_stop;
                        end else begin
                            state <= S_IDLE;
                            tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
